// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Sequenced instruction fetch with stall skid buffer and branch
//            redirect. Optional fetch counter enabled by FETCH_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int          MEM_SIZE = 10,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        isBranchTaken,
    input  logic [31:0] in_Addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] Inst_Out,
    output logic [31:0] PC_Out,
    output logic        inst_valid,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0] fetch_cnt,
`endif
    output logic        flush
);

    localparam logic [31:0] c_mem_size = 32'(MEM_SIZE);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_HOLD = 3'd2,
        S_DROP = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_inst;
    logic [31:0] r_pc_out;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_valid;
    logic        r_skid_valid;
    logic        r_flush;
    logic [31:0] w_pc_inc;
    logic        w_consume;
    logic        w_load_out;
    logic        w_load_skid;
    logic        w_skid_to_out;
    logic        w_advance;

    assign w_pc_inc   = r_pc + 32'd1;
    assign w_consume  = r_valid & ~stall;
    assign mem_req    = (r_state == S_REQ) || (r_state == S_DROP);
    // While draining a squashed request the old address must stay on the bus.
    assign mem_addr   = (r_state == S_DROP) ? r_drop_addr : r_pc;
    assign Inst_Out   = r_inst;
    assign PC_Out     = r_pc_out;
    assign inst_valid = r_valid;
    assign flush      = r_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        w_advance     = 1'b0;
        if (isBranchTaken) begin
            if ((r_state == S_REQ) && !mem_ack) begin
                w_next_state = S_DROP;
            end else if (in_Addr < c_mem_size) begin
                w_next_state = S_REQ;
            end else begin
                w_next_state = S_HALT;
            end
        end else begin
            case (r_state)
                S_IDLE: w_next_state = (r_pc < c_mem_size) ? S_REQ : S_HALT;
                S_REQ: begin
                    if (mem_ack) begin
                        w_advance = 1'b1;
                        if (!r_valid || w_consume) begin
                            w_load_out   = 1'b1;
                            w_next_state = (w_pc_inc >= c_mem_size) ? S_HALT : S_REQ;
                        end else begin
                            w_load_skid  = 1'b1;
                            w_next_state = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_consume) begin
                        w_skid_to_out = r_skid_valid;
                        w_next_state  = (r_pc >= c_mem_size) ? S_HALT : S_REQ;
                    end
                end
                S_DROP: begin
                    if (mem_ack) begin
                        w_next_state = (r_pc < c_mem_size) ? S_REQ : S_HALT;
                    end
                end
                S_HALT:  w_next_state = S_HALT;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_drop_addr  <= RESET_PC;
            r_inst       <= 32'd0;
            r_pc_out     <= 32'd0;
            r_skid_inst  <= 32'd0;
            r_skid_pc    <= 32'd0;
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_flush      <= 1'b0;
        end else begin
            r_flush <= isBranchTaken;
            if (isBranchTaken) begin
                r_pc         <= in_Addr;
                r_valid      <= 1'b0;
                r_skid_valid <= 1'b0;
                if (w_next_state == S_DROP) begin
                    r_drop_addr <= r_pc;
                end
            end else begin
                if (w_advance) begin
                    r_pc <= w_pc_inc;
                end
                if (w_load_out) begin
                    r_inst   <= mem_rdata;
                    r_pc_out <= r_pc;
                    r_valid  <= 1'b1;
                end else if (w_skid_to_out) begin
                    r_inst       <= r_skid_inst;
                    r_pc_out     <= r_skid_pc;
                    r_valid      <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_consume) begin
                    r_valid <= 1'b0;
                end
                if (w_load_skid) begin
                    r_skid_inst  <= mem_rdata;
                    r_skid_pc    <= r_pc;
                    r_skid_valid <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] r_fetch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_consume) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl with a latency-
//            programmable instruction memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        isBranchTaken;
    logic [31:0] in_Addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] Inst_Out;
    logic [31:0] PC_Out;
    logic        inst_valid;
    logic        flush;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt;
`endif

    int n_checks;
    int n_errors;
    int lat;
    int wait_cnt;
    logic ack_force;

    fetch_ctrl #(
        .MEM_SIZE (10),
        .RESET_PC (32'd0)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .isBranchTaken (isBranchTaken),
        .in_Addr       (in_Addr),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .Inst_Out      (Inst_Out),
        .PC_Out        (PC_Out),
        .inst_valid    (inst_valid),
`ifdef FETCH_CTRL_PERF_EN
        .fetch_cnt     (fetch_cnt),
`endif
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack after 'lat' waiting cycles, data tagged with address.
    assign mem_ack   = ack_force | (mem_req && (wait_cnt >= lat));
    assign mem_rdata = 32'hA000_0000 + mem_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (mem_req && !mem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        stall         = 1'b0;
        isBranchTaken = 1'b0;
        in_Addr       = 32'd0;
        lat           = 0;
        ack_force     = 1'b0;

        // Reset state
        step();
        check("rst_req",   mem_req, 1'b0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_inst",  Inst_Out, 32'd0);
        check("rst_pcout", PC_Out, 32'd0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_flush", flush, 1'b0);

        // Zero-wait streaming to HALT
        rst = 1'b0;
        step();
        check("t1_first_req", mem_req, 1'b1);
        check("t1_first_val", inst_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t1_pc",    PC_Out, 32'(i));
            check("t1_inst",  Inst_Out, 32'hA000_0000 + 32'(i));
            check("t1_valid", inst_valid, 1'b1);
        end
        check("t1_halt_req", mem_req, 1'b0);
        step();
        check("t1_drain_valid", inst_valid, 1'b0);
        check("t1_halt_req2",   mem_req, 1'b0);

        // Restart from HALT, then skid buffer under a 3-cycle stall
        isBranchTaken = 1'b1;
        in_Addr       = 32'd0;
        step();
        isBranchTaken = 1'b0;
        check("t2_flush", flush, 1'b1);
        check("t2_valid", inst_valid, 1'b0);
        check("t2_req",   mem_req, 1'b1);
        check("t2_addr",  mem_addr, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_pc", PC_Out, 32'(i));
            if (i == 0) check("t2_flush_off", flush, 1'b0);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold_req",   mem_req, 1'b0);
            check("t2_hold_pc",    PC_Out, 32'd2);
            check("t2_hold_valid", inst_valid, 1'b1);
        end
        stall = 1'b0;
        step();
        check("t2_skid_pc",   PC_Out, 32'd3);
        check("t2_skid_inst", Inst_Out, 32'hA000_0003);
        check("t2_resume",    mem_req, 1'b1);
        check("t2_res_addr",  mem_addr, 32'd4);

        // Two-cycle latency, branch to 7 while PC 4 is outstanding
        lat = 2;
        step();
        check("t3_pend_valid", inst_valid, 1'b0);
        check("t3_pend_addr",  mem_addr, 32'd4);
        isBranchTaken = 1'b1;
        in_Addr       = 32'd7;
        step();
        isBranchTaken = 1'b0;
        check("t3_flush",     flush, 1'b1);
        check("t3_valid",     inst_valid, 1'b0);
        check("t3_drop_req",  mem_req, 1'b1);
        check("t3_drop_addr", mem_addr, 32'd4);
        step();
        check("t3_flush_off", flush, 1'b0);
        check("t3_new_addr",  mem_addr, 32'd7);
        check("t3_discard",   inst_valid, 1'b0);
        for (int k = 0; k < 8 && !inst_valid; k++) step();
        check("t3_out_valid", inst_valid, 1'b1);
        check("t3_out_pc",    PC_Out, 32'd7);
        check("t3_out_inst",  Inst_Out, 32'hA000_0007);

        // Branch out of range halts; branch back in range resumes
        lat           = 0;
        isBranchTaken = 1'b1;
        in_Addr       = 32'd12;
        step();
        isBranchTaken = 1'b0;
        check("t4_halt_req", mem_req, 1'b0);
        check("t4_flush",    flush, 1'b1);
        check("t4_valid",    inst_valid, 1'b0);
        step();
        check("t4_halt_req2", mem_req, 1'b0);
        check("t4_flush_off", flush, 1'b0);
        isBranchTaken = 1'b1;
        in_Addr       = 32'd1;
        step();
        isBranchTaken = 1'b0;
        check("t4_res_req",  mem_req, 1'b1);
        check("t4_res_addr", mem_addr, 32'd1);
        step();
        check("t4_out_pc",   PC_Out, 32'd1);
        check("t4_out_inst", Inst_Out, 32'hA000_0001);

        // Asynchronous reset with a request pending
        lat = 5;
        step();
        check("t5_pend_req",  mem_req, 1'b1);
        check("t5_pend_addr", mem_addr, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t5_req",   mem_req, 1'b0);
        check("t5_addr",  mem_addr, 32'd0);
        check("t5_inst",  Inst_Out, 32'd0);
        check("t5_pcout", PC_Out, 32'd0);
        check("t5_valid", inst_valid, 1'b0);
        check("t5_flush", flush, 1'b0);
        ack_force = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check("t5_idle_ack_ign", inst_valid, 1'b0);
        check("t5_restart_req",  mem_req, 1'b1);
        check("t5_restart_addr", mem_addr, 32'd0);
        ack_force = 1'b0;
        lat       = 0;
        step();
        check("t5_out_pc",   PC_Out, 32'd0);
        check("t5_out_inst", Inst_Out, 32'hA000_0000);
`ifdef FETCH_CTRL_PERF_EN
        check("t6_cnt0", fetch_cnt, 32'd0);
`endif

        // Five consumes, a stalled branch, two more consumes
        for (int i = 0; i < 5; i++) step();
        check("t6_pc5", PC_Out, 32'd5);
        stall         = 1'b1;
        isBranchTaken = 1'b1;
        in_Addr       = 32'd0;
        step();
        stall         = 1'b0;
        isBranchTaken = 1'b0;
        check("t6_flush", flush, 1'b1);
        check("t6_valid", inst_valid, 1'b0);
        step();
        check("t6_pc0", PC_Out, 32'd0);
        step();
        step();
        check("t6_pc2", PC_Out, 32'd2);
`ifdef FETCH_CTRL_PERF_EN
        check("t6_cnt7", fetch_cnt, 32'd7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
